fa_bist_ctrl: RTL and testbench

- Hardware stimulus generator and response checker for a 3-input/2-output full-adder DUT (inputs a, b, c; outputs sum, carry).
- Sweeps all 8 input vectors PASSES times, waits a settle interval per vector, then compares the DUT response against the ideal full-adder function.
- Reports pass/fail, an error count and the first failing vector.
- Sits beside the DUT on the FPGA for on-board self-test; no simulation-only constructs.

---
 rtl/fa_bist_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fa_bist_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_bist_ctrl.sv
// Built-in self-test controller for a full-adder: sweeps all 8 input vectors, checks each response.
// Define FA_BIST_FAILMAP_EN to add the per-vector fail_map output.
//
// state   | meaning
// S_IDLE  | results cleared, waiting for start
// S_DRIVE | vector applied, settle timer running
// S_CHECK | one-cycle compare of the DUT response against the ideal adder
// S_DONE  | results held, start launches a fresh run
module fa_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       first_fail_vec,
  output logic [1:0]       first_fail_resp
`ifdef FA_BIST_FAILMAP_EN
  ,
  output logic [7:0]       fail_map
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      vec_idx, vec_nxt;
  logic [PW-1:0]   pass_cnt, pcnt_nxt;
  logic [SW-1:0]   settle_cnt, scnt_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic            fv_nxt;
  logic [2:0]      ffv_nxt;
  logic [1:0]      ffr_nxt;
  logic            clr;
  logic [1:0]      exp_resp;
  logic            mismatch;
`ifdef FA_BIST_FAILMAP_EN
  logic [7:0]      fmap_nxt;
`endif

  // vec_idx is a register, so the stimulus is glitch-free and stable across DRIVE+CHECK
  assign {dut_a, dut_b, dut_c} = vec_idx;

  assign exp_resp = {^vec_idx,
                     (vec_idx[2] & vec_idx[1]) | (vec_idx[2] & vec_idx[0]) | (vec_idx[1] & vec_idx[0])};
  assign mismatch = ({dut_sum, dut_carry} != exp_resp);

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_idx;
    pcnt_nxt  = pass_cnt;
    scnt_nxt  = settle_cnt;
    err_nxt   = err_cnt;
    fv_nxt    = fail_valid;
    ffv_nxt   = first_fail_vec;
    ffr_nxt   = first_fail_resp;
    clr       = 1'b0;
`ifdef FA_BIST_FAILMAP_EN
    fmap_nxt  = fail_map;
`endif
    unique case (state)
      S_IDLE: begin
        clr = 1'b1;
        if (start) state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        if (abort) begin
          clr       = 1'b1;
          state_nxt = S_IDLE;
        end else if (settle_cnt == '0) begin
          state_nxt = S_CHECK;
        end else begin
          scnt_nxt = settle_cnt - SW'(1);
        end
      end
      S_CHECK: begin
        if (abort) begin
          clr       = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          if (mismatch) begin
            if (err_cnt != {ERR_W{1'b1}}) err_nxt = err_cnt + ERR_W'(1);
            if (!fail_valid) begin
              fv_nxt  = 1'b1;
              ffv_nxt = vec_idx;
              ffr_nxt = {dut_sum, dut_carry};
            end
`ifdef FA_BIST_FAILMAP_EN
            fmap_nxt[vec_idx] = 1'b1;
`endif
          end
          if (vec_idx != 3'd7) begin
            vec_nxt   = vec_idx + 3'd1;
            state_nxt = S_DRIVE;
          end else if (pass_cnt != PASS_LAST) begin
            vec_nxt   = 3'd0;
            pcnt_nxt  = pass_cnt + PW'(1);
            state_nxt = S_DRIVE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (clr) begin
      vec_nxt  = '0;
      pcnt_nxt = '0;
      scnt_nxt = '0;
      err_nxt  = '0;
      fv_nxt   = 1'b0;
      ffv_nxt  = '0;
      ffr_nxt  = '0;
`ifdef FA_BIST_FAILMAP_EN
      fmap_nxt = '0;
`endif
    end
    // settle timer counts down from SETTLE_CYCLES-1 on every entry into DRIVE
    if (state_nxt == S_DRIVE && state != S_DRIVE) scnt_nxt = SETTLE_LOAD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      vec_idx         <= '0;
      pass_cnt        <= '0;
      settle_cnt      <= '0;
      err_cnt         <= '0;
      fail_valid      <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_resp <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
`ifdef FA_BIST_FAILMAP_EN
      fail_map        <= '0;
`endif
    end else begin
      state           <= state_nxt;
      vec_idx         <= vec_nxt;
      pass_cnt        <= pcnt_nxt;
      settle_cnt      <= scnt_nxt;
      err_cnt         <= err_nxt;
      fail_valid      <= fv_nxt;
      first_fail_vec  <= ffv_nxt;
      first_fail_resp <= ffr_nxt;
      busy            <= (state_nxt == S_DRIVE) || (state_nxt == S_CHECK);
      done            <= (state_nxt == S_DONE);
      pass            <= (state_nxt == S_DONE) && (err_nxt == '0);
`ifdef FA_BIST_FAILMAP_EN
      fail_map        <= fmap_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Self-checking bench for fa_bist_ctrl: three instances with different parameters, a
// configurable faulty full-adder model per instance, and an arithmetic reference of the run results.
module tb_fa_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start_v [3];
  logic abort_v [3];
  logic [1:0] mask [8];

  wire [2:0] stim_v [3];
  wire       sum_v [3];
  wire       carry_v [3];
  wire       busy_v [3];
  wire       done_v [3];
  wire       pass_v [3];
  wire       fv_v [3];
  wire [2:0] ffv_v [3];
  wire [1:0] ffr_v [3];
  wire [7:0] err_v [3];
  wire [7:0] err_a, err_c;
  wire [1:0] err_b;
`ifdef FA_BIST_FAILMAP_EN
  wire [7:0] map_v [3];
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam int SC [3] = '{2, 1, 2};
  localparam int NP [3] = '{1, 3, 2};
  localparam int EW [3] = '{8, 2, 8};

  always #5 clk = ~clk;

  assign err_v[0] = err_a;
  assign err_v[1] = {6'd0, err_b};
  assign err_v[2] = err_c;

  // Faulty full adder: ideal response (ones count of the inputs) flipped by mask[{a,b,c}] = {sum,carry}
  for (genvar g = 0; g < 3; g++) begin : g_model
    wire [1:0] cnt = 2'(stim_v[g][2]) + 2'(stim_v[g][1]) + 2'(stim_v[g][0]);
    assign sum_v[g]   = cnt[0] ^ mask[stim_v[g]][1];
    assign carry_v[g] = cnt[1] ^ mask[stim_v[g]][0];
  end

  fa_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .dut_a(stim_v[0][2]), .dut_b(stim_v[0][1]), .dut_c(stim_v[0][0]),
    .dut_sum(sum_v[0]), .dut_carry(carry_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_a),
    .fail_valid(fv_v[0]), .first_fail_vec(ffv_v[0]), .first_fail_resp(ffr_v[0])
`ifdef FA_BIST_FAILMAP_EN
    , .fail_map(map_v[0])
`endif
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(3), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .dut_a(stim_v[1][2]), .dut_b(stim_v[1][1]), .dut_c(stim_v[1][0]),
    .dut_sum(sum_v[1]), .dut_carry(carry_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_b),
    .fail_valid(fv_v[1]), .first_fail_vec(ffv_v[1]), .first_fail_resp(ffr_v[1])
`ifdef FA_BIST_FAILMAP_EN
    , .fail_map(map_v[1])
`endif
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
    .dut_a(stim_v[2][2]), .dut_b(stim_v[2][1]), .dut_c(stim_v[2][0]),
    .dut_sum(sum_v[2]), .dut_carry(carry_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_c),
    .fail_valid(fv_v[2]), .first_fail_vec(ffv_v[2]), .first_fail_resp(ffr_v[2])
`ifdef FA_BIST_FAILMAP_EN
    , .fail_map(map_v[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fa_ref(input int v);
    int ones;
    ones = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
    return {ones[0], ones[1]};
  endfunction

  task automatic set_mask_ideal();
    for (int v = 0; v < 8; v++) mask[v] = 2'b00;
  endtask

  // Launch a run on instance i and compare the held results with the reference model.
  task automatic run_check(input int i, input bit with_abort, input string tag);
    int n_bad, first, exp_err, lim, edges, n_exp;
    logic [7:0] exp_map;
    n_bad = 0; first = -1; exp_map = 8'd0;
    for (int v = 0; v < 8; v++) begin
      if (mask[v] != 2'b00) begin
        n_bad++;
        if (first < 0) first = v;
        exp_map[v] = 1'b1;
      end
    end
    exp_err = NP[i] * n_bad;
    if (exp_err > (1 << EW[i]) - 1) exp_err = (1 << EW[i]) - 1;
    n_exp = 8 * NP[i] * (SC[i] + 1);
    lim   = n_exp + 20;

    @(negedge clk);
    start_v[i] = 1'b1;
    abort_v[i] = with_abort;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    abort_v[i] = 1'b0;
    chk({tag, "_busy0"}, 32'(busy_v[i]), 32'd1);
    chk({tag, "_clr"}, 32'(err_v[i]), 32'd0);
    edges = 0;
    while (edges < lim) begin
      @(posedge clk);
      edges++;
      #1;
      if (done_v[i]) break;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(n_exp));
    @(negedge clk);
    chk({tag, "_done"}, 32'(done_v[i]), 32'd1);
    chk({tag, "_busy"}, 32'(busy_v[i]), 32'd0);
    chk({tag, "_pass"}, 32'(pass_v[i]), 32'(exp_err == 0));
    chk({tag, "_err"}, 32'(err_v[i]), 32'(exp_err));
    chk({tag, "_fv"}, 32'(fv_v[i]), 32'(first >= 0));
    if (first >= 0) begin
      chk({tag, "_ffv"}, 32'(ffv_v[i]), 32'(first));
      chk({tag, "_ffr"}, 32'(ffr_v[i]), 32'(fa_ref(first) ^ mask[first]));
    end else begin
      chk({tag, "_ffv"}, 32'(ffv_v[i]), 32'd0);
      chk({tag, "_ffr"}, 32'(ffr_v[i]), 32'd0);
    end
`ifdef FA_BIST_FAILMAP_EN
    chk({tag, "_map"}, 32'(map_v[i]), 32'(exp_map));
`endif
  endtask

  task automatic wait_vec(input int i, input int v, input string tag);
    int k = 0;
    while (stim_v[i] != 3'(v) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reach"}, 32'(stim_v[i]), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    set_mask_ideal();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_err", 32'(err_v[0]), 32'd0);
    chk("rst_stim", 32'(stim_v[0]), 32'd0);
    rst_n = 1'b1;

    run_check(0, 1'b0, "ideal0");

    // carry = a|b
    mask[2] = 2'b01;
    mask[4] = 2'b01;
    run_check(0, 1'b0, "cor");
    chk("cor_err_lit", 32'(err_v[0]), 32'd2);
    chk("cor_ffv_lit", 32'(ffv_v[0]), 32'b010);
    chk("cor_ffr_lit", 32'(ffr_v[0]), 32'b11);
`ifdef FA_BIST_FAILMAP_EN
    chk("cor_map_lit", 32'(map_v[0]), 32'b0001_0100);
`endif

    // abort in DONE has no effect
    @(negedge clk);
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_v[0] = 1'b0;
    chk("done_abort_done", 32'(done_v[0]), 32'd1);
    chk("done_abort_err", 32'(err_v[0]), 32'd2);

    // start wins over abort in DONE
    set_mask_ideal();
    run_check(0, 1'b1, "startwin");

    // sum stuck at 0
    set_mask_ideal();
    for (int v = 0; v < 8; v++) if (fa_ref(v) & 2'b10) mask[v] = 2'b10;
    run_check(2, 1'b0, "s0p2");
    chk("s0p2_err_lit", 32'(err_v[2]), 32'd8);
    chk("s0p2_ffv_lit", 32'(ffv_v[2]), 32'b001);
    chk("s0p2_ffr_lit", 32'(ffr_v[2]), 32'b00);
`ifdef FA_BIST_FAILMAP_EN
    chk("s0p2_map_lit", 32'(map_v[2]), 32'b1001_0110);
`endif
    run_check(1, 1'b0, "s0sat");
    chk("s0sat_err_lit", 32'(err_v[1]), 32'd3);

    // restart from DONE on the ideal adder clears and recomputes
    set_mask_ideal();
    run_check(1, 1'b0, "restart");

    // abort mid-run at vector 5 after two failures were recorded
    mask[2] = 2'b01;
    mask[4] = 2'b01;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_vec(0, 5, "ab");
    chk("ab_err_before", 32'(err_v[0]), 32'd2);
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_v[0] = 1'b0;
    chk("ab_busy", 32'(busy_v[0]), 32'd0);
    chk("ab_done", 32'(done_v[0]), 32'd0);
    chk("ab_err", 32'(err_v[0]), 32'd0);
    chk("ab_fv", 32'(fv_v[0]), 32'd0);
    set_mask_ideal();
    run_check(0, 1'b0, "after_ab");

    // synchronous reset mid-run at vector 3
    for (int v = 0; v < 8; v++) if (fa_ref(v) & 2'b10) mask[v] = 2'b10;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_vec(0, 3, "mr");
    chk("mr_err_before", 32'(err_v[0]), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_busy", 32'(busy_v[0]), 32'd0);
    chk("mr_done", 32'(done_v[0]), 32'd0);
    chk("mr_pass", 32'(pass_v[0]), 32'd0);
    chk("mr_err", 32'(err_v[0]), 32'd0);
    chk("mr_fv", 32'(fv_v[0]), 32'd0);
    chk("mr_ffv", 32'(ffv_v[0]), 32'd0);
    chk("mr_ffr", 32'(ffr_v[0]), 32'd0);
    chk("mr_stim", 32'(stim_v[0]), 32'd0);
`ifdef FA_BIST_FAILMAP_EN
    chk("mr_map", 32'(map_v[0]), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    set_mask_ideal();
    run_check(0, 1'b0, "after_rst");

    // random fault tables on random instances
    for (int r = 0; r < 10; r++) begin
      for (int v = 0; v < 8; v++)
        mask[v] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      run_check(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
